// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, command constants and helpers
package ps2_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_WAIT_FIRST,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RESP_ACK     = 8'hFA;
  localparam int FILTER_LEN = 8;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer with optional stability filter and falling-edge pulse
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter bit FILTER = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);
  logic s1, s2;
  // two-flop synchronizer, idle level of an open-drain line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= line;
      s2 <= s1;
    end
  end
  generate
    if (FILTER) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN);
      localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
      logic [CW-1:0] cnt;
      // level follows the synchronized line only after FILTER_LEN consecutive differing samples
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          level <= 1'b1;
          fall  <= 1'b0;
        end else begin
          fall <= 1'b0;
          if (s2 == level) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            level <= s2;
            fall  <= ~s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end else begin : g_sync
      // unfiltered: level is the synchronized line, fall marks its 1->0 step
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          level <= 1'b1;
          fall  <= 1'b0;
        end else begin
          level <= s2;
          fall  <= level & ~s2;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15_000,
  parameter int FRAME_TIMEOUT_US = 2_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int CPU     = CLK_FREQ_HZ / 1_000_000;
  localparam int N_INH   = CPU * INHIBIT_US;
  localparam int N_START = CPU * START_TIMEOUT_US;
  localparam int N_FRAME = CPU * FRAME_TIMEOUT_US;
  localparam int W_INH   = $clog2(N_INH);
  localparam int W_START = $clog2(N_START);
  localparam int W_FRAME = $clog2(N_FRAME);
  localparam int W_MAX   = W_INH > W_START ? (W_INH > W_FRAME ? W_INH : W_FRAME)
                                           : (W_START > W_FRAME ? W_START : W_FRAME);
  localparam int TW      = W_MAX < 1 ? 1 : W_MAX;
  localparam logic [TW-1:0] T_INH   = TW'(N_INH - 1);
  localparam logic [TW-1:0] T_START = TW'(N_START - 1);
  localparam logic [TW-1:0] T_FRAME = TW'(N_FRAME - 1);
  state_t state, state_n;
  logic [TW-1:0] t, t_n;
  logic [3:0] cnt, cnt_n;
  logic [8:0] sh, sh_n;
  logic clk_oe_n, data_oe_n, done_n, err_n;
  logic clk_lvl, clk_fall, data_lvl, unused_data_fall;
  ps2_line_filter #(.FILTER(1'b1)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .line(ps2_clk_i), .level(clk_lvl), .fall(clk_fall)
  );
  ps2_line_filter #(.FILTER(1'b0)) u_data_sync (
    .clk(clk), .rst_n(rst_n), .line(ps2_data_i), .level(data_lvl), .fall(unused_data_fall)
  );
  assign tx_ready = (state == S_IDLE) & ~tx_done & ~tx_err;
  assign busy     = ~tx_ready;
  // state, shared timer, bit counter and registered line drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      t           <= '0;
      cnt         <= '0;
      sh          <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_n;
      t           <= t_n;
      cnt         <= cnt_n;
      sh          <= sh_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
    end
  end
  // next state and next line drive; timeouts are checked before fall so they win
  always_comb begin
    state_n   = state;
    t_n       = t + 1'b1;
    cnt_n     = cnt;
    sh_n      = sh;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      S_IDLE: begin
        t_n = '0;
        if (tx_valid && tx_ready) begin
          state_n   = S_INHIBIT;
          sh_n      = {odd_parity(tx_data), tx_data};
          clk_oe_n  = 1'b1;
          data_oe_n = (T_INH == '0);
        end
      end
      S_INHIBIT: begin
        if (t == T_INH) begin
          state_n   = S_WAIT_FIRST;
          t_n       = '0;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
        end else begin
          data_oe_n = (t_n == T_INH);
        end
      end
      S_WAIT_FIRST: begin
        if (t == T_START) begin
          err_n = 1'b1;
        end else if (clk_fall) begin
          state_n   = S_SHIFT;
          t_n       = '0;
          cnt_n     = 4'd1;
          data_oe_n = ~sh[0];
        end
      end
      S_SHIFT: begin
        if (t == T_FRAME) begin
          err_n = 1'b1;
        end else if (clk_fall) begin
          cnt_n     = cnt + 1'b1;
          data_oe_n = (cnt == 4'd9) ? 1'b0 : ~sh[cnt];
          state_n   = (cnt == 4'd9) ? S_ACK : S_SHIFT;
        end
      end
      S_ACK: begin
        if (t == T_FRAME) begin
          err_n = 1'b1;
        end else if (clk_fall) begin
          err_n   = data_lvl;
          state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (t == T_FRAME) begin
          err_n = 1'b1;
        end else if (clk_lvl && data_lvl) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (err_n) begin
      state_n   = S_IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with an open-drain PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int N_INH   = 100;
  localparam int N_START = 15_000;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_i, ps2_data_i;
  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0;
  logic [10:0] exp_q[$];

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000), .INHIBIT_US(100), .START_TIMEOUT_US(15_000), .FRAME_TIMEOUT_US(2_000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err), .busy(busy), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input bit track);
    int n = 0;
    while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL send_ready_wait got=%b want=1", tx_ready); end
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    total++;
    if ({busy, ps2_clk_oe} !== 2'b11) begin
      bad++; $display("FAIL accept_busy_clk_oe got=%b want=11", {busy, ps2_clk_oe});
    end
    if (track) exp_q.push_back(frame_of(b));
  endtask

  task automatic wait_release(output int n, output int d);
    n = 0;
    d = 0;
    while (ps2_clk_oe && n < 1000) begin
      d += int'(ps2_data_oe);
      n++;
      @(negedge clk);
    end
    total++;
    if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL inhibit_release got=%b want=0", ps2_clk_oe); end
  endtask

  task automatic dev_run(input int pulses, input bit ack_bit, input bit glitch, output logic [10:0] bits);
    bits = '0;
    repeat (30) @(negedge clk);
    bits[0] = ps2_data_i;
    for (int i = 1; i <= pulses; i++) begin
      if (i == 11) dev_data = ack_bit;
      dev_clk = 1'b0;
      repeat (40) @(negedge clk);
      if (i <= 10) bits[i] = ps2_data_i;
      dev_clk = 1'b1;
      if (glitch && i == 5) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (22) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic check_frame(input logic [10:0] bits, input string name);
    logic [10:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL %s no expected frame, got=%b", name, bits);
    end else begin
      e = exp_q.pop_front();
      if (bits !== e) begin bad++; $display("FAIL %s frame got=%b want=%b", name, bits, e); end
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 5000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++;
    if (n >= 5000) begin bad++; $display("FAIL end_wait timed out got=none want=done_or_err"); end
  endtask

  task automatic test_reset();
    total++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=100000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err});
    end
  endtask

  task automatic test_idle_fall();
    int d0 = done_cnt, e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; repeat (20) @(negedge clk);
      dev_clk = 1'b1; repeat (20) @(negedge clk);
    end
    total++;
    if ({tx_ready, ps2_clk_oe, ps2_data_oe} !== 3'b100) begin
      bad++; $display("FAIL idle_fall_state got=%b want=100", {tx_ready, ps2_clk_oe, ps2_data_oe});
    end
    total++;
    if (done_cnt != d0 || err_cnt != e0) begin
      bad++; $display("FAIL idle_fall_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0, e0);
    end
  endtask

  task automatic test_enable();
    int d0 = done_cnt, e0 = err_cnt, n, d;
    logic [10:0] bits;
    send(CMD_ENABLE, 1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    total++;
    if (tx_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", tx_ready); end
    tx_valid = 1'b0;
    wait_release(n, d);
    dev_run(11, 1'b0, 1'b0, bits);
    check_frame(bits, "enable");
    n = 0;
    while (!tx_done && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (tx_done !== 1'b1 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL done_cycle_ready got=%b%b want=10", tx_done, tx_ready);
    end
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_after_done got=%b want=1", tx_ready); end
    total++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      bad++; $display("FAIL enable_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_reset_cmd();
    int d0 = done_cnt, e0 = err_cnt, n, d;
    logic [10:0] bits;
    send(CMD_RESET, 1'b1);
    wait_release(n, d);
    total++;
    if (n != N_INH) begin bad++; $display("FAIL inhibit_len got=%0d want=%0d", n, N_INH); end
    total++;
    if (d != 1) begin bad++; $display("FAIL start_in_inhibit got=%0d want=1", d); end
    total++;
    if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL start_held got=%b want=1", ps2_data_oe); end
    dev_run(11, 1'b0, 1'b0, bits);
    check_frame(bits, "reset_cmd");
    wait_end(d0, e0);
    total++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      bad++; $display("FAIL reset_cmd_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_start_timeout();
    int d0 = done_cnt, e0 = err_cnt, n, d;
    send(CMD_ENABLE, 1'b0);
    wait_release(n, d);
    n = 0;
    while (!tx_err && n < N_START + 100) begin @(negedge clk); n++; end
    total++;
    if (n != N_START) begin bad++; $display("FAIL start_timeout got=%0d want=%0d", n, N_START); end
    total++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      bad++; $display("FAIL timeout_release got=%b want=00", {ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk);
    total++;
    if (done_cnt != d0 || err_cnt != e0 + 1 || tx_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_pulses got=%0d/%0d/%b want=%0d/%0d/1", done_cnt, err_cnt, tx_ready, d0, e0 + 1);
    end
  endtask

  task automatic test_nack();
    int d0 = done_cnt, e0 = err_cnt, n, d;
    logic [10:0] bits;
    send(CMD_SET_RATE, 1'b1);
    wait_release(n, d);
    dev_run(11, 1'b1, 1'b0, bits);
    check_frame(bits, "nack");
    wait_end(d0, e0);
    total++;
    if (done_cnt != d0 || err_cnt != e0 + 1) begin
      bad++; $display("FAIL nack_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0, e0 + 1);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send(CMD_ENABLE, 1'b1);
    wait_release(n, d);
    dev_run(11, 1'b0, 1'b0, bits);
    check_frame(bits, "after_nack");
    wait_end(d0, e0);
    total++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      bad++; $display("FAIL after_nack_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt, e0 = err_cnt, n, d;
    logic [10:0] bits;
    send(8'hA5, 1'b1);
    wait_release(n, d);
    dev_run(11, 1'b0, 1'b1, bits);
    check_frame(bits, "glitch");
    wait_end(d0, e0);
    total++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      bad++; $display("FAIL glitch_pulses got=%0d/%0d want=%0d/%0d", done_cnt, err_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, e0, n, d;
    logic [10:0] bits;
    send(8'h00, 1'b0);
    wait_release(n, d);
    dev_run(5, 1'b0, 1'b0, bits);
    total++;
    if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL bit4_driven got=%b want=1", ps2_data_oe); end
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      bad++; $display("FAIL async_reset got=%b want=001", {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (done_cnt != d0 || err_cnt != e0 || tx_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset got=%0d/%0d/%b want=%0d/%0d/1", done_cnt, err_cnt, tx_ready, d0, e0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_idle_fall();
    test_enable();
    test_reset_cmd();
    test_start_timeout();
    test_nack();
    test_glitch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
